// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly in front of decode. It owns the
//   fetch PC, issues word requests to instruction memory, buffers the
//   in-order responses with their PCs in a small prefetch FIFO and presents
//   one instruction per cycle to decode. A redirect flushes the FIFO, turns
//   every still-pending request into one whose response is dropped, and
//   restarts fetch at the new (word-aligned) PC.
//
// Ports
//   clk            rising-edge clock
//   reset_i        synchronous active-high reset
//   req_valid_o    fetch request valid
//   req_addr_o     byte address of requested word (bits [1:0] always 0)
//   req_ready_i    memory accepts the request this cycle
//   resp_valid_i   response word valid (always accepted)
//   resp_data_i    instruction word, returned in request order
//   instr_valid_o  FIFO head valid
//   instr_o        head instruction
//   instr_pc_o     PC of head instruction
//   instr_ready_i  decode consumes the head this cycle
//   redirect_i     flush and restart fetch
//   redirect_pc_i  new fetch PC (bits [1:0] ignored)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset_i,
    output logic                  req_valid_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    input  logic                  req_ready_i,
    input  logic                  resp_valid_i,
    input  logic [31:0]           resp_data_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

    // Counter width holds 0..DEPTH; pointer width indexes DEPTH slots.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = ADDR_WIDTH'(RESET_PC) & ALIGN_MASK;
    localparam logic [CW:0]           DEPTH_W     = (CW + 1)'(DEPTH);

    // Architectural state
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]         live_q,     live_d;
    logic [CW-1:0]         discard_q,  discard_d;
    logic [CW-1:0]         count_q,    count_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;

    // Prefetch FIFO storage: instruction word and its PC per slot
    logic [31:0]           data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

    // Handshake / event decode
    logic          req_fire;
    logic          resp_drop;
    logic          resp_keep;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // Every slot that is pending in memory or sitting in the FIFO holds a
    // credit; a new request is only issued while a credit is free, which is
    // what keeps the FIFO from ever overflowing.
    assign occupancy = {1'b0, live_q} + {1'b0, discard_q} + {1'b0, count_q};

    assign req_valid_o = !reset_i && !redirect_i && (occupancy < DEPTH_W);
    assign req_addr_o  = fetch_pc_q;

    assign req_fire  = req_valid_o && req_ready_i;
    // A response first pays off any outstanding discards; only then is it kept.
    // A response with nothing pending is ignored (neither term fires).
    assign resp_drop = resp_valid_i && (discard_q != '0);
    assign resp_keep = resp_valid_i && (discard_q == '0) && (live_q != '0);

    assign instr_valid_o = !reset_i && (count_q != '0);
    assign instr_o       = data_q[rd_ptr_q];
    assign instr_pc_o    = pc_q[rd_ptr_q];

    // Redirect flushes the FIFO, so neither push nor pop takes effect then.
    assign push = resp_keep && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ALIGN_MASK;
            resp_pc_d  = redirect_pc_i & ALIGN_MASK;
            // Everything still pending becomes a discard, minus the one
            // response (kept or dropped) that retires in this very cycle.
            discard_d  = discard_q + live_q - CW'(resp_drop || resp_keep);
            live_d     = '0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + PC_STEP;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            live_d    = live_q + CW'(req_fire) - CW'(resp_keep);
            discard_d = discard_q - CW'(resp_drop);
            count_d   = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC_AL;
            resp_pc_q  <= RESET_PC_AL;
            live_q     <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !reset_i) begin
            data_q[wr_ptr_q] <= resp_data_i;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit against an in-order variable-latency memory model and
//   compares every cycle against a queue-based reference: a list of pending
//   memory requests (each tagged keep/drop) and a list of PCs expected at
//   decode, in order.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          req_valid_o;
    logic [AW-1:0] req_addr_o;
    logic          req_ready_i;
    logic          resp_valid_i;
    logic [31:0]   resp_data_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_ready_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .req_ready_i   (req_ready_i),
        .resp_valid_i  (resp_valid_i),
        .resp_data_i   (resp_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        bit            kept;
    } mreq_t;

    mreq_t         mem_q[$];     // requests accepted by memory, in order
    logic [AW-1:0] exp_fifo[$];  // PCs expected at decode, in order
    logic [AW-1:0] m_fetch_pc;
    int            cyc;
    int            n_tests;
    int            n_fail;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, then
    // advance the reference model across the edge.
    task automatic step(input logic rst, input logic redir, input logic [AW-1:0] rpc,
                        input logic rq_rdy, input logic in_rdy, input int lat);
        logic  exp_rv;
        logic  exp_iv;
        mreq_t e;
        reset_i       = rst;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        req_ready_i   = rq_rdy;
        instr_ready_i = in_rdy;
        resp_valid_i  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        resp_data_i   = resp_valid_i ? mem_word(mem_q[0].addr) : $urandom();
        #1;
        exp_rv = !rst && !redir && ((mem_q.size() + exp_fifo.size()) < DEPTH);
        exp_iv = !rst && (exp_fifo.size() > 0);
        check("req_valid", {31'b0, req_valid_o}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", {24'b0, req_addr_o}, {24'b0, m_fetch_pc});
        check("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_iv});
        if (exp_iv) begin
            check("instr_pc", {24'b0, instr_pc_o}, {24'b0, exp_fifo[0]});
            check("instr_data", instr_o, mem_word(exp_fifo[0]));
        end
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
            exp_fifo.delete();
            m_fetch_pc = '0;
        end else begin
            if (in_rdy && !redir && exp_fifo.size() > 0) void'(exp_fifo.pop_front());
            if (resp_valid_i) begin
                e = mem_q.pop_front();
                if (e.kept) exp_fifo.push_back(e.addr);
            end
            if (exp_rv && rq_rdy) begin
                mem_q.push_back('{m_fetch_pc, cyc + lat, 1'b1});
                m_fetch_pc = m_fetch_pc + 8'd4;
            end
            if (redir) begin
                foreach (mem_q[i]) mem_q[i].kept = 1'b0;
                exp_fifo.delete();
                m_fetch_pc = rpc & 8'hFC;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic          r_rst;
        logic          r_redir;
        logic [AW-1:0] r_pc;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_fetch_pc    = '0;
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        req_ready_i   = 1'b0;
        resp_valid_i  = 1'b0;
        resp_data_i   = '0;
        instr_ready_i = 1'b0;
        @(negedge clk);

        // Reset, then 1-cycle memory with decode always ready
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1);
        repeat (20) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        // Decode stalled: buffer fills to DEPTH, requests stop, head stays PC 0
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1);
        repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);
        check("stall_head_pc", {24'b0, instr_pc_o}, 32'h0);
        check("stall_head_valid", {31'b0, instr_valid_o}, 32'h1);
        check("stall_req_valid", {31'b0, req_valid_o}, 32'h0);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        // 3-cycle memory, redirect to 0x40 while requests are pending
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3);
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 3);
        repeat (12) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3);

        // Redirect coinciding with a response and a pop
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        // Address wrap and unaligned redirect target
        step(1'b0, 1'b1, 8'hF8, 1'b1, 1'b1, 1);
        repeat (12) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        // Back-to-back redirects with slow memory
        step(1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1, 8'h90, 1'b1, 1'b1, 2);
        repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2);

        // Reset with requests in flight, then restart at 0
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3);
        repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3);

        // Randomized traffic
        repeat (800) begin
            r_rst   = ($urandom_range(0, 99) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_pc    = 8'($urandom());
            step(r_rst, r_redir, r_pc, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)));
        end
        repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
